// File: rtl/single_macc_decimator.sv
// Decimating 16-tap FIR built around a single time-shared signed 18x18 MAC.
// Define SINGLE_MACC_DECIMATOR_ROUND_EN to round half up before the output shift.
module single_macc_decimator #(
  parameter int DecimationK = 2
) (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic        CoeffClk_i,
  input  logic [3:0]  CoeffAddr_i,
  input  logic [17:0] CoeffData_i,
  input  logic        CoeffWr_i,
  input  logic [17:0] Data_i,
  input  logic        DataNd_i,
  output logic [17:0] Data_o,
  output logic        DataValid_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_SAT  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;
  localparam logic [3:0] CNT_LAST = 4'(DecimationK - 1);

  logic [17:0]        r_coeff [16];
  logic [17:0]        r_buf   [32];
  logic [4:0]         r_wptr;
  logic [4:0]         r_base;
  logic [3:0]         r_cnt;
  logic [3:0]         r_tap;
  logic [1:0]         r_state;
  logic signed [39:0] r_acc;
  logic [17:0]        r_res;

  logic               w_unused_coeff_clk;
  logic               w_start;
  logic [4:0]         w_rd_idx;
  logic signed [35:0] w_coef_ext;
  logic signed [35:0] w_samp_ext;
  logic signed [35:0] w_prod;
  logic signed [39:0] w_acc_adj;
  logic signed [39:0] w_shift;
  logic [17:0]        w_sat;

  assign w_unused_coeff_clk = CoeffClk_i;

  // A trigger that lands while a pass is running is dropped; the counter still advances.
  assign w_start = DataNd_i && (r_cnt == CNT_LAST) && (r_state == S_IDLE);

  assign w_rd_idx   = r_base - 5'(r_tap);
  assign w_coef_ext = {{18{r_coeff[r_tap][17]}}, r_coeff[r_tap]};
  assign w_samp_ext = {{18{r_buf[w_rd_idx][17]}}, r_buf[w_rd_idx]};
  assign w_prod     = w_coef_ext * w_samp_ext;

`ifdef SINGLE_MACC_DECIMATOR_ROUND_EN
  assign w_acc_adj = r_acc + 40'sd65536;
`else
  assign w_acc_adj = r_acc;
`endif
  assign w_shift = w_acc_adj >>> 17;

  always_comb begin
    w_sat = w_shift[17:0];
    if (w_shift > 40'sd131071)       w_sat = 18'h1FFFF;
    else if (w_shift < -40'sd131072) w_sat = 18'h20000;
  end

  // Coefficient RAM deliberately survives reset.
  always_ff @(posedge Clk_i) begin
    if (CoeffWr_i) r_coeff[CoeffAddr_i] <= CoeffData_i;
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (DataNd_i) begin
      r_buf[r_wptr] <= Data_i;
      r_wptr        <= r_wptr + 5'd1;
      r_cnt         <= (r_cnt == CNT_LAST) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_base      <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      Data_o      <= '0;
      DataValid_o <= 1'b0;
    end else begin
      DataValid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_MAC;
            r_base  <= r_wptr;
            r_tap   <= '0;
            r_acc   <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + {{4{w_prod[35]}}, w_prod};
          r_tap <= r_tap + 4'd1;
          if (r_tap == 4'd15) r_state <= S_SAT;
        end
        S_SAT: begin
          r_res   <= w_sat;
          r_state <= S_OUT;
        end
        default: begin
          Data_o      <= r_res;
          DataValid_o <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_single_macc_decimator.sv
// Randomized bench for single_macc_decimator against a sample-history FIR model.
`timescale 1ns/1ps
module tb_single_macc_decimator;
  localparam int K = 2;

  logic        Clk_i = 1'b0;
  logic        Rst_i;
  logic        CoeffClk_i;
  logic [3:0]  CoeffAddr_i;
  logic [17:0] CoeffData_i;
  logic        CoeffWr_i;
  logic [17:0] Data_i;
  logic        DataNd_i;
  logic [17:0] Data_o;
  logic        DataValid_o;

  single_macc_decimator #(.DecimationK(K)) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .CoeffClk_i(CoeffClk_i),
    .CoeffAddr_i(CoeffAddr_i), .CoeffData_i(CoeffData_i), .CoeffWr_i(CoeffWr_i),
    .Data_i(Data_i), .DataNd_i(DataNd_i), .Data_o(Data_o), .DataValid_o(DataValid_o)
  );

  always #5 Clk_i = ~Clk_i;

  int cyc = 0;
  always @(posedge Clk_i) cyc <= cyc + 1;

  typedef struct { int t; int d; } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];

  always @(negedge Clk_i) begin : mon
    ev_t e;
    if (DataValid_o) begin
      e.t = cyc;
      e.d = int'($signed(Data_o));
      obs_q.push_back(e);
    end
  end

  int coef_m[16];
  int hist[$];
  int cnt_m = 0;
  int last_trig = -1000;
  int checks = 0;
  int errors = 0;

  // Direct FIR over the accepted-sample history since reset.
  function automatic int model_out();
    longint acc;
    int n;
    acc = 0;
    n = hist.size() - 1;
    for (int k = 0; k < 16; k++)
      if (n - k >= 0) acc += longint'(coef_m[k]) * longint'(hist[n - k]);
`ifdef SINGLE_MACC_DECIMATOR_ROUND_EN
    acc += 65536;
`endif
    acc = acc >>> 17;
    if (acc > 131071) return 131071;
    if (acc < -131072) return -131072;
    return int'(acc);
  endfunction

  task automatic write_coeff(input int k, input int v);
    CoeffAddr_i = 4'(k);
    CoeffData_i = 18'(v);
    CoeffWr_i   = 1'b1;
    @(negedge Clk_i);
    CoeffWr_i = 1'b0;
    coef_m[k] = v;
  endtask

  // Send one sample; the next sample may follow gap clocks later.
  task automatic push(input int x, input int gap);
    int t;
    ev_t e;
    Data_i   = 18'(x);
    DataNd_i = 1'b1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    t = cyc;
    hist.push_back(x);
    cnt_m++;
    if (cnt_m == K) begin
      cnt_m = 0;
      if (t - last_trig > 18) begin
        last_trig = t;
        e.t = t + 18;
        e.d = model_out();
        exp_q.push_back(e);
      end
    end
    repeat (gap - 1) @(negedge Clk_i);
  endtask

  task automatic model_reset();
    while (exp_q.size() > 0 && exp_q[$].t > cyc) void'(exp_q.pop_back());
    hist.delete();
    cnt_m = 0;
    last_trig = -1000;
  endtask

  task automatic do_reset();
    Rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge Clk_i);
    Rst_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (Data_o !== 18'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", Data_o); end
    checks++;
    if (DataValid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", DataValid_o); end
    repeat (20) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL reset_idle: got %0d outputs expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_impulse();
    do_reset();
    for (int k = 0; k < 16; k++) write_coeff(k, 1000 * (k + 1));
    push(131071, 16);
    for (int i = 0; i < 19; i++) push(0, 16);
    repeat (24) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() !== 10) begin
      errors++; $display("FAIL impulse_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].d !== exp_q[i].d) begin
        errors++; $display("FAIL impulse_out%0d: got t=%0d d=%0d expected t=%0d d=%0d",
                           i, obs_q[i].t, obs_q[i].d, exp_q[i].t, exp_q[i].d);
      end
      checks++;
      if (obs_q[i].d !== ((i < 8) ? 2000 * (i + 1) - 1 : 0)) begin
        errors++; $display("FAIL impulse_value%0d: got %0d expected %0d", i, obs_q[i].d, (i < 8) ? 2000 * (i + 1) - 1 : 0);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_dc();
    do_reset();
    for (int k = 0; k < 16; k++) write_coeff(k, 8192);
    for (int i = 0; i < 20; i++) push(65536, 16);
    repeat (24) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL dc_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].d !== exp_q[i].d) begin
        errors++; $display("FAIL dc_out%0d: got t=%0d d=%0d expected t=%0d d=%0d",
                           i, obs_q[i].t, obs_q[i].d, exp_q[i].t, exp_q[i].d);
      end
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[$].d !== 65536) begin
      errors++; $display("FAIL dc_settled: got %0d expected 65536", (obs_q.size() > 0) ? obs_q[$].d : -1);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 16; k++) write_coeff(k, 131071);
    for (int i = 0; i < 16; i++) push(131071, 16);
    for (int i = 0; i < 16; i++) push(-131072, 16);
    repeat (24) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() !== 16) begin
      errors++; $display("FAIL sat_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].d !== exp_q[i].d) begin
        errors++; $display("FAIL sat_out%0d: got t=%0d d=%0d expected t=%0d d=%0d",
                           i, obs_q[i].t, obs_q[i].d, exp_q[i].t, exp_q[i].d);
      end
    end
    if (obs_q.size() == 16) begin
      checks++;
      if (obs_q[7].d !== 131071) begin errors++; $display("FAIL sat_pos: got %0d expected 131071", obs_q[7].d); end
      checks++;
      if (obs_q[15].d !== -131072) begin errors++; $display("FAIL sat_neg: got %0d expected -131072", obs_q[15].d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midpass();
    do_reset();
    for (int k = 0; k < 16; k++) write_coeff(k, int'($urandom_range(262143)) - 131072);
    push(100000, 16);
    push(-90000, 30);
    push(70000, 16);
    push(50000, 6);
    Rst_i = 1'b1;
    #1;
    checks++;
    if (Data_o !== 18'd0) begin errors++; $display("FAIL midreset_data: got %0d expected 0", Data_o); end
    checks++;
    if (DataValid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", DataValid_o); end
    model_reset();
    repeat (2) @(negedge Clk_i);
    Rst_i = 1'b0;
    push(40000, 30);
    push(-30000, 16);
    repeat (24) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() !== 2) begin
      errors++; $display("FAIL midreset_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].d !== exp_q[i].d) begin
        errors++; $display("FAIL midreset_out%0d: got t=%0d d=%0d expected t=%0d d=%0d",
                           i, obs_q[i].t, obs_q[i].d, exp_q[i].t, exp_q[i].d);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 16; k++) write_coeff(k, int'($urandom_range(262143)) - 131072);
    for (int i = 0; i < 80; i++) push(int'($urandom_range(262143)) - 131072, int'($urandom_range(24, 1)));
    repeat (24) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].d !== exp_q[i].d) begin
        errors++; $display("FAIL random_out%0d: got t=%0d d=%0d expected t=%0d d=%0d",
                           i, obs_q[i].t, obs_q[i].d, exp_q[i].t, exp_q[i].d);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 16; k++) write_coeff(k, int'($urandom_range(262143)) - 131072);
    for (int i = 0; i < 45; i++) push(int'($urandom_range(262143)) - 131072, 1);
    repeat (24) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].t !== exp_q[i].t || obs_q[i].d !== exp_q[i].d) begin
        errors++; $display("FAIL b2b_out%0d: got t=%0d d=%0d expected t=%0d d=%0d",
                           i, obs_q[i].t, obs_q[i].d, exp_q[i].t, exp_q[i].d);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_round();
    int want;
`ifdef SINGLE_MACC_DECIMATOR_ROUND_EN
    want = 1;
`else
    want = 0;
`endif
    do_reset();
    write_coeff(0, 1);
    for (int k = 1; k < 16; k++) write_coeff(k, 0);
    push(65536, 16);
    push(65536, 16);
    repeat (24) @(negedge Clk_i);
    checks++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      errors++; $display("FAIL round_count: got %0d outputs expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].t !== exp_q[0].t || obs_q[0].d !== want) begin
        errors++; $display("FAIL round_out: got t=%0d d=%0d expected t=%0d d=%0d", obs_q[0].t, obs_q[0].d, exp_q[0].t, want);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    Rst_i = 1'b1; CoeffClk_i = 1'b0; CoeffAddr_i = '0; CoeffData_i = '0; CoeffWr_i = 1'b0;
    Data_i = '0; DataNd_i = 1'b0;
    repeat (2) @(negedge Clk_i);
    Rst_i = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_reset_midpass();
    test_random();
    test_back_to_back();
    test_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
